lsfr_draw_ctrl: RTL and testbench



---
 rtl/lsfr_draw_ctrl_pkg.sv | 20 ++
 rtl/lsfr_draw_ctrl_if.sv | 42 ++++
 rtl/lsfr_draw_ctrl_rr_arbiter.sv | 31 +++
 rtl/lsfr_draw_ctrl.sv | 126 ++++++++++++
 tb/tb_lsfr_draw_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsfr_draw_ctrl_pkg.sv
// Shared types and constants for the LFSR draw controller slice.
// Holds the random word width, the draw FSM state type and an index-width helper.
package lsfr_ctrl_pkg;

  localparam int unsigned RND_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT,
    CHECK,
    DONE
  } draw_state_t;

  // Index width for a set of n items, never narrower than one bit.
  function automatic int unsigned owner_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lsfr_draw_ctrl_if.sv
// Requester/LFSR-side signal bundle for lsfr_draw_ctrl.
// master = the controller, slave = requesters plus the lsfr instance.
interface lsfr_draw_ctrl_if
  import lsfr_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ = 4
);

  localparam int unsigned OW = owner_w(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             rnd_valid;
  logic [RND_W-1:0] rnd_out;
  logic [OW-1:0]    rnd_owner;
  logic             err;
  logic             change;
  logic [RND_W-1:0] rnd;

  modport master (
    input  req,
    input  rnd,
    output gnt,
    output rnd_valid,
    output rnd_out,
    output rnd_owner,
    output err,
    output change
  );

  modport slave (
    output req,
    output rnd,
    input  gnt,
    input  rnd_valid,
    input  rnd_out,
    input  rnd_owner,
    input  err,
    input  change
  );

endinterface

// File: rtl/lsfr_draw_ctrl_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last winner
// and wraps, so the previous owner has the lowest priority.
module rr_arbiter
  import lsfr_ctrl_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = owner_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] winner
);

  int unsigned w_idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    w_idx  = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_idx = int'(last) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!valid && req[w_idx]) begin
        valid  = 1'b1;
        winner = w_idx[W-1:0];
      end
    end
  end

endmodule

// File: rtl/lsfr_draw_ctrl.sv
// Shares one lsfr source among N_REQ requesters: round-robin arbitration, a
// change pulse per attempt, settle delay, rejection sampling and tagged result.
module lsfr_draw_ctrl
  import lsfr_ctrl_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned SETTLE    = 1,
  parameter int unsigned LIMIT     = 8192,
  parameter int unsigned MAX_RETRY = 3
) (
  input logic               clock,
  input logic               reset,
  lsfr_draw_ctrl_if.master  bus
);

  localparam int unsigned   OW  = owner_w(N_REQ);
  localparam int unsigned   CW  = owner_w(SETTLE + 1);
  localparam int unsigned   RW  = owner_w(MAX_RETRY + 1);
  localparam logic [RND_W:0] LIM = LIMIT[RND_W:0];

  draw_state_t      r_state;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [RW-1:0]    r_retry;
  logic [N_REQ-1:0] r_gnt;
  logic             r_valid;
  logic [RND_W-1:0] r_rnd_out;
  logic [OW-1:0]    r_owner_out;
  logic             r_err;
  logic             r_change;

  logic             w_req_any;
  logic [OW-1:0]    w_win;
  logic             w_accept;
  logic [N_REQ-1:0] w_onehot;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .req    (bus.req),
    .last   (r_ptr),
    .valid  (w_req_any),
    .winner (w_win)
  );

  always_comb begin
    w_accept = ({1'b0, bus.rnd} < LIM);
    w_onehot = '0;
    w_onehot[r_owner] = 1'b1;
  end

  // Result registers load on the CHECK->DONE edge so they are valid in DONE
  // and then hold until the next DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_ptr       <= OW'(N_REQ - 1);
      r_cnt       <= '0;
      r_retry     <= '0;
      r_gnt       <= '0;
      r_valid     <= 1'b0;
      r_rnd_out   <= '0;
      r_owner_out <= '0;
      r_err       <= 1'b0;
      r_change    <= 1'b0;
    end else begin
      r_change <= 1'b0;
      r_valid  <= 1'b0;
      r_gnt    <= '0;
      case (r_state)
        IDLE: begin
          if (w_req_any) begin
            r_owner  <= w_win;
            r_retry  <= '0;
            r_change <= 1'b1;
            r_state  <= PULSE;
          end
        end
        PULSE: begin
          r_cnt   <= CW'(SETTLE);
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= CHECK;
        end
        CHECK: begin
          if (w_accept) begin
            r_rnd_out   <= bus.rnd;
            r_err       <= 1'b0;
            r_valid     <= 1'b1;
            r_gnt       <= w_onehot;
            r_owner_out <= r_owner;
            r_state     <= DONE;
          end else if (r_retry < RW'(MAX_RETRY)) begin
            r_retry  <= r_retry + 1'b1;
            r_change <= 1'b1;
            r_state  <= PULSE;
          end else begin
            r_rnd_out   <= '0;
            r_err       <= 1'b1;
            r_valid     <= 1'b1;
            r_gnt       <= w_onehot;
            r_owner_out <= r_owner;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_ptr   <= r_owner;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rnd_valid = r_valid;
  assign bus.rnd_out   = r_rnd_out;
  assign bus.rnd_owner = r_owner_out;
  assign bus.err       = r_err;
  assign bus.change    = r_change;

endmodule

// File: tb/tb_lsfr_draw_ctrl.sv
// Directed bench for lsfr_draw_ctrl: instance A never rejects, instance B uses LIMIT=100.
// A stub lsfr feeds a per-test table of rnd values, one per change pulse.
module tb_lsfr_draw_ctrl;

  logic clock;
  logic reset;

  int checks;
  int errors;

  logic [12:0] stub [8];
  int          stub_n;

  lsfr_draw_ctrl_if #(.N_REQ(4)) bus_a ();
  lsfr_draw_ctrl_if #(.N_REQ(4)) bus_b ();

  lsfr_draw_ctrl #(
    .N_REQ(4), .SETTLE(1), .LIMIT(8192), .MAX_RETRY(3)
  ) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  lsfr_draw_ctrl #(
    .N_REQ(4), .SETTLE(1), .LIMIT(100), .MAX_RETRY(3)
  ) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Steps cycles from the accepting edge; cycle c is observed at the c-th negedge.
  task automatic watch(input int sel, input int budget,
                       output int vcyc, output int nchg, output int dbl,
                       output logic [3:0] g, output logic [12:0] ro,
                       output logic [1:0] ow, output logic e);
    int   k;
    logic prev;
    logic ch;
    logic v;
    vcyc = -1; nchg = 0; dbl = 0; g = '0; ro = '0; ow = '0; e = 1'b0;
    k = 0; prev = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clock);
      ch = (sel == 0) ? bus_a.change : bus_b.change;
      v  = (sel == 0) ? bus_a.rnd_valid : bus_b.rnd_valid;
      if (ch && prev) dbl++;
      prev = ch;
      if (ch) begin
        nchg++;
        if (sel == 0) bus_a.rnd = stub[(k < stub_n) ? k : stub_n - 1];
        else          bus_b.rnd = stub[(k < stub_n) ? k : stub_n - 1];
        k++;
      end
      if (v) begin
        vcyc = c;
        if (sel == 0) begin
          g = bus_a.gnt; ro = bus_a.rnd_out; ow = bus_a.rnd_owner; e = bus_a.err;
        end else begin
          g = bus_b.gnt; ro = bus_b.rnd_out; ow = bus_b.rnd_owner; e = bus_b.err;
        end
        break;
      end
    end
  endtask

  task automatic test_reset();
    int vc, nc, db; logic [3:0] g; logic [12:0] ro; logic [1:0] ow; logic e;
    reset = 1'b1;
    bus_a.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if ({bus_a.rnd_valid, bus_a.gnt, bus_a.rnd_out, bus_a.rnd_owner, bus_a.err, bus_a.change} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got v=%b g=%b ro=%h ow=%0d e=%b ch=%b exp all 0",
                 i, bus_a.rnd_valid, bus_a.gnt, bus_a.rnd_out, bus_a.rnd_owner, bus_a.err, bus_a.change);
      end
    end
    reset = 1'b0;
    stub[0] = 13'h0111; stub_n = 1;
    watch(0, 20, vc, nc, db, g, ro, ow, e);
    bus_a.req = 4'b0000;
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got %b exp 0001", g); end
    checks++; if (vc !== 4) begin errors++; $display("FAIL reset_first_latency got %0d exp 4", vc); end
  endtask

  task automatic test_single_draw();
    int vc, nc, db; logic [3:0] g; logic [12:0] ro; logic [1:0] ow; logic e;
    repeat (2) @(negedge clock);
    stub[0] = 13'h0ABC; stub_n = 1;
    bus_a.req = 4'b0100;
    @(negedge clock);
    checks++; if (bus_a.change !== 1'b1) begin errors++; $display("FAIL single_change_cyc1 got %b exp 1", bus_a.change); end
    bus_a.rnd = stub[0];
    watch(0, 20, vc, nc, db, g, ro, ow, e);
    bus_a.req = 4'b0000;
    checks++; if (vc !== 3) begin errors++; $display("FAIL single_valid_cycle got %0d exp 4", vc + 1); end
    checks++; if (nc !== 0) begin errors++; $display("FAIL single_extra_change got %0d exp 0", nc); end
    checks++; if (ro !== 13'h0ABC) begin errors++; $display("FAIL single_rnd_out got %h exp 0abc", ro); end
    checks++; if (ow !== 2'd2) begin errors++; $display("FAIL single_owner got %0d exp 2", ow); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", e); end
    checks++; if (g !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", g); end
    repeat (3) @(negedge clock);
    checks++;
    if ({bus_a.rnd_valid, bus_a.gnt, bus_a.rnd_out, bus_a.rnd_owner, bus_a.err} !== {1'b0, 4'b0000, 13'h0ABC, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL single_hold got v=%b g=%b ro=%h ow=%0d e=%b exp v=0 g=0000 ro=0abc ow=2 e=0",
               bus_a.rnd_valid, bus_a.gnt, bus_a.rnd_out, bus_a.rnd_owner, bus_a.err);
    end
  endtask

  task automatic test_zero_value();
    int vc, nc, db; logic [3:0] g; logic [12:0] ro; logic [1:0] ow; logic e;
    repeat (2) @(negedge clock);
    stub[0] = 13'h0000; stub_n = 1;
    bus_a.req = 4'b1000;
    watch(0, 20, vc, nc, db, g, ro, ow, e);
    bus_a.req = 4'b0000;
    checks++;
    if ({g, ro, ow, e} !== {4'b1000, 13'h0000, 2'd3, 1'b0} || vc !== 4) begin
      errors++;
      $display("FAIL zero_value got g=%b ro=%h ow=%0d e=%b vc=%0d exp g=1000 ro=0 ow=3 e=0 vc=4", g, ro, ow, e, vc);
    end
  endtask

  task automatic test_fairness();
    int vc, nc, db; logic [3:0] g; logic [12:0] ro; logic [1:0] ow; logic e;
    logic [3:0] exp_g [7];
    int         exp_c [7];
    exp_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_c = '{4, 5, 5, 5, 5, 5, 5};
    stub[0] = 13'h0123; stub_n = 1;
    @(negedge clock);
    reset = 1'b1;
    bus_a.req = 4'b1011;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      watch(0, 20, vc, nc, db, g, ro, ow, e);
      bus_a.req = bus_a.req & ~g;
      if (i == 2) bus_a.req = 4'b1111;
      checks++;
      if (g !== exp_g[i] || vc !== exp_c[i]) begin
        errors++;
        $display("FAIL fairness_grant_%0d got g=%b at %0d exp g=%b at %0d", i, g, vc, exp_g[i], exp_c[i]);
      end
    end
    bus_a.req = 4'b0000;
  endtask

  task automatic test_rejection();
    int vc, nc, db; logic [3:0] g; logic [12:0] ro; logic [1:0] ow; logic e;
    repeat (2) @(negedge clock);
    stub[0] = 13'd5000; stub[1] = 13'd5000; stub[2] = 13'd42; stub_n = 3;
    bus_b.req = 4'b0001;
    watch(1, 40, vc, nc, db, g, ro, ow, e);
    bus_b.req = 4'b0000;
    checks++; if (nc !== 3) begin errors++; $display("FAIL reject_change_count got %0d exp 3", nc); end
    checks++; if (vc !== 10) begin errors++; $display("FAIL reject_valid_cycle got %0d exp 10", vc); end
    checks++; if (ro !== 13'd42 || e !== 1'b0) begin errors++; $display("FAIL reject_result got ro=%0d e=%b exp ro=42 e=0", ro, e); end
    checks++; if (g !== 4'b0001 || ow !== 2'd0) begin errors++; $display("FAIL reject_owner got g=%b ow=%0d exp g=0001 ow=0", g, ow); end
    checks++; if (db !== 0) begin errors++; $display("FAIL reject_change_consecutive got %0d exp 0", db); end
  endtask

  task automatic test_limit_boundary();
    int vc, nc, db; logic [3:0] g; logic [12:0] ro; logic [1:0] ow; logic e;
    repeat (2) @(negedge clock);
    stub[0] = 13'd100; stub[1] = 13'd99; stub_n = 2;
    bus_b.req = 4'b0010;
    watch(1, 40, vc, nc, db, g, ro, ow, e);
    bus_b.req = 4'b0000;
    checks++;
    if (nc !== 2 || vc !== 7 || ro !== 13'd99 || e !== 1'b0 || ow !== 2'd1) begin
      errors++;
      $display("FAIL limit_boundary got nc=%0d vc=%0d ro=%0d e=%b ow=%0d exp nc=2 vc=7 ro=99 e=0 ow=1", nc, vc, ro, e, ow);
    end
  endtask

  task automatic test_exhaustion();
    int vc, nc, db; logic [3:0] g; logic [12:0] ro; logic [1:0] ow; logic e;
    repeat (2) @(negedge clock);
    stub[0] = 13'd7000; stub_n = 1;
    bus_b.req = 4'b0100;
    watch(1, 40, vc, nc, db, g, ro, ow, e);
    bus_b.req = 4'b0000;
    checks++; if (nc !== 4) begin errors++; $display("FAIL exhaust_change_count got %0d exp 4", nc); end
    checks++; if (vc !== 13) begin errors++; $display("FAIL exhaust_valid_cycle got %0d exp 13", vc); end
    checks++; if (e !== 1'b1 || ro !== 13'd0) begin errors++; $display("FAIL exhaust_result got e=%b ro=%0d exp e=1 ro=0", e, ro); end
    checks++; if (g !== 4'b0100 || ow !== 2'd2) begin errors++; $display("FAIL exhaust_owner got g=%b ow=%0d exp g=0100 ow=2", g, ow); end
    checks++; if (db !== 0) begin errors++; $display("FAIL exhaust_change_consecutive got %0d exp 0", db); end
  endtask

  task automatic test_reset_mid_draw();
    int vc, nc, db; logic [3:0] g; logic [12:0] ro; logic [1:0] ow; logic e;
    repeat (2) @(negedge clock);
    stub[0] = 13'h0555; stub_n = 1;
    bus_a.req = 4'b0001;
    watch(0, 20, vc, nc, db, g, ro, ow, e);
    bus_a.req = 4'b0000;
    checks++; if (g !== 4'b0001 || ro !== 13'h0555) begin errors++; $display("FAIL midrst_setup got g=%b ro=%h exp g=0001 ro=0555", g, ro); end
    repeat (2) @(negedge clock);
    bus_a.req = 4'b0100;
    @(negedge clock);
    checks++; if (bus_a.change !== 1'b1) begin errors++; $display("FAIL midrst_change got %b exp 1", bus_a.change); end
    @(negedge clock);
    reset = 1'b1;
    bus_a.req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if ({bus_a.rnd_valid, bus_a.gnt, bus_a.rnd_out, bus_a.rnd_owner, bus_a.err, bus_a.change} !== '0) begin
        errors++;
        $display("FAIL midrst_outputs cycle %0d got v=%b g=%b ro=%h ow=%0d e=%b ch=%b exp all 0",
                 i, bus_a.rnd_valid, bus_a.gnt, bus_a.rnd_out, bus_a.rnd_owner, bus_a.err, bus_a.change);
      end
    end
    reset = 1'b0;
    watch(0, 20, vc, nc, db, g, ro, ow, e);
    bus_a.req = 4'b0000;
    checks++; if (g !== 4'b0001 || vc !== 4) begin errors++; $display("FAIL midrst_next_gnt got g=%b at %0d exp g=0001 at 4", g, vc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus_a.req = 4'b0000;
    bus_b.req = 4'b0000;
    bus_a.rnd = 13'h1FFF;
    bus_b.rnd = 13'h1FFF;
    stub_n = 1;
    for (int i = 0; i < 8; i++) stub[i] = 13'h0000;
    test_reset();
    test_single_draw();
    test_zero_value();
    test_fairness();
    test_rejection();
    test_limit_boundary();
    test_exhaustion();
    test_reset_mid_draw();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
